// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: program memory read port plus the decoder-facing control and
// instruction outputs.
//   master : fetch stage (drives address, ir, ir_pc, ir_valid, halted, fetch_count)
//   slave  : memory/decoder side (drives I, stall, halt, branch_*)
interface pc_fetch_if #(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24,
  parameter int unsigned Csize = 16
);
  logic [Psize-1:0] address;
  logic [Isize:0]   I;
  logic             stall;
  logic             halt;
  logic             branch_abs;
  logic             branch_rel;
  logic [Psize-1:0] branch_target;
  logic [Psize-1:0] branch_offset;
  logic [Isize:0]   ir;
  logic [Psize-1:0] ir_pc;
  logic             ir_valid;
  logic             halted;
  logic [Csize-1:0] fetch_count;

  modport master (
    output address, ir, ir_pc, ir_valid, halted, fetch_count,
    input  I, stall, halt, branch_abs, branch_rel, branch_target, branch_offset
  );

  modport slave (
    input  address, ir, ir_pc, ir_valid, halted, fetch_count,
    output I, stall, halt, branch_abs, branch_rel, branch_target, branch_offset
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage. Holds the PC, drives the program memory read address
// combinationally and registers the returned word into ir for the decoder.
// Handles stall, absolute/relative branches (one-slot squash), halt and a
// saturating count of delivered instructions.
// Ports:
//   Clock  : system clock, rising edge
//   Reset  : synchronous, active-high
//   bus    : pc_fetch_if master modport (memory address/data, control, ir outputs)
module pc_fetch #(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24,
  parameter int unsigned Csize = 16
) (
  input logic        Clock,
  input logic        Reset,
  pc_fetch_if.master bus
);

  typedef enum logic {StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic [Isize:0]   ir_q, ir_d;
  logic [Psize-1:0] ir_pc_q, ir_pc_d;
  logic             ir_valid_q, ir_valid_d;
  logic             halted_q, halted_d;
  logic [Csize-1:0] cnt_q, cnt_d;

  logic             take_abs, take_rel;
  logic [Psize-1:0] rel_target;

  // Branch/halt requests refer to the instruction in ir, so they only count
  // while that instruction is live.
  assign take_abs   = ir_valid_q & bus.branch_abs;
  assign take_rel   = ir_valid_q & bus.branch_rel & ~bus.branch_abs;
  // Same-width add wraps modulo 2^Psize, matching a sign-extended offset.
  assign rel_target = ir_pc_q + bus.branch_offset;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StRun: begin
        if (take_abs || take_rel) begin
          // Squash the wrong-path word; ir/ir_pc keep the branch instruction.
          pc_d       = take_abs ? bus.branch_target : rel_target;
          ir_valid_d = 1'b0;
        end else if (ir_valid_q && bus.halt) begin
          state_d    = StHalted;
          halted_d   = 1'b1;
          ir_valid_d = 1'b0;
        end else if (!bus.stall) begin
          ir_d       = bus.I;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + Psize'(1);
          if (cnt_q != {Csize{1'b1}}) cnt_d = cnt_q + Csize'(1);
        end
      end
      StHalted: ;  // frozen until Reset
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StRun;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.address     = pc_q;
  assign bus.ir          = ir_q;
  assign bus.ir_pc       = ir_pc_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: default-size instance plus a Csize=3 instance
// for counter saturation. Program memory holds mem[a] = a + 1.
module tb_pc_fetch;

  logic Clock;
  logic Reset;
  int   n_vec;
  int   n_err;

  logic [24:0] mem [64];

  pc_fetch_if #(.Psize(6), .Isize(24), .Csize(16)) bus ();
  pc_fetch_if #(.Psize(6), .Isize(24), .Csize(3))  bus3 ();

  pc_fetch #(.Psize(6), .Isize(24), .Csize(16)) u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  pc_fetch #(.Psize(6), .Isize(24), .Csize(3)) u_dut3 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus3.master)
  );

  assign bus.I  = mem[bus.address];
  assign bus3.I = mem[bus3.address];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " address"}, 32'(bus.address), 32'd0);
    check({tag, " ir"}, 32'(bus.ir), 32'd0);
    check({tag, " ir_pc"}, 32'(bus.ir_pc), 32'd0);
    check({tag, " ir_valid"}, 32'(bus.ir_valid), 32'd0);
    check({tag, " halted"}, 32'(bus.halted), 32'd0);
    check({tag, " count"}, 32'(bus.fetch_count), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 25'(i + 1);
    bus.stall = 0; bus.halt = 0; bus.branch_abs = 0; bus.branch_rel = 0;
    bus.branch_target = '0; bus.branch_offset = '0;
    bus3.stall = 0; bus3.halt = 0; bus3.branch_abs = 0; bus3.branch_rel = 0;
    bus3.branch_target = '0; bus3.branch_offset = '0;

    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check_zero("reset");

    // Five plain fetches
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("seq ir", 32'(bus.ir), 32'(k));
      check("seq ir_pc", 32'(bus.ir_pc), 32'(k - 1));
      check("seq ir_valid", 32'(bus.ir_valid), 32'd1);
    end
    check("seq count", 32'(bus.fetch_count), 32'd5);
    check("seq address", 32'(bus.address), 32'd5);

    // Walk to pc=63 then wrap
    for (int k = 0; k < 58; k++) tick();
    check("pre-wrap address", 32'(bus.address), 32'd63);
    tick();
    check("wrap ir_pc", 32'(bus.ir_pc), 32'd63);
    check("wrap ir", 32'(bus.ir), 32'd64);
    check("wrap address", 32'(bus.address), 32'd0);
    tick();
    check("post-wrap ir_pc", 32'(bus.ir_pc), 32'd0);
    check("post-wrap ir", 32'(bus.ir), 32'd1);
    check("post-wrap count", 32'(bus.fetch_count), 32'd65);

    // Stall three cycles at pc=10
    for (int k = 0; k < 9; k++) tick();
    check("pre-stall address", 32'(bus.address), 32'd10);
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall address", 32'(bus.address), 32'd10);
      check("stall ir", 32'(bus.ir), 32'd10);
      check("stall ir_pc", 32'(bus.ir_pc), 32'd9);
      check("stall ir_valid", 32'(bus.ir_valid), 32'd1);
      check("stall count", 32'(bus.fetch_count), 32'd74);
    end
    bus.stall = 0;
    tick();
    check("resume ir_pc", 32'(bus.ir_pc), 32'd10);
    check("resume ir", 32'(bus.ir), 32'd11);
    check("resume count", 32'(bus.fetch_count), 32'd75);

    // Relative branch -4 from ir_pc=20 with a simultaneous stall
    for (int k = 0; k < 10; k++) tick();
    check("pre-rel ir_pc", 32'(bus.ir_pc), 32'd20);
    bus.branch_rel = 1; bus.branch_offset = 6'b111100; bus.stall = 1;
    tick();
    bus.branch_rel = 0; bus.stall = 0;
    check("rel address", 32'(bus.address), 32'd16);
    check("rel ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rel ir_pc held", 32'(bus.ir_pc), 32'd20);
    check("rel ir held", 32'(bus.ir), 32'd21);
    check("rel count", 32'(bus.fetch_count), 32'd85);
    tick();
    check("rel tgt ir_pc", 32'(bus.ir_pc), 32'd16);
    check("rel tgt ir", 32'(bus.ir), 32'd17);
    check("rel tgt ir_valid", 32'(bus.ir_valid), 32'd1);

    // abs + rel together: abs wins
    bus.branch_abs = 1; bus.branch_rel = 1; bus.branch_target = 6'd40; bus.branch_offset = 6'd5;
    tick();
    bus.branch_rel = 0; bus.branch_target = 6'd7;
    check("abs prio address", 32'(bus.address), 32'd40);
    check("abs prio ir_valid", 32'(bus.ir_valid), 32'd0);

    // branch_abs still high, but ir_valid=0 so it is ignored
    tick();
    bus.branch_abs = 0;
    check("unqual abs address", 32'(bus.address), 32'd41);
    check("unqual abs ir_pc", 32'(bus.ir_pc), 32'd40);
    check("unqual abs ir_valid", 32'(bus.ir_valid), 32'd1);
    check("unqual abs count", 32'(bus.fetch_count), 32'd87);

    // Halt and stay frozen against noisy inputs
    bus.halt = 1;
    tick();
    check("halt halted", 32'(bus.halted), 32'd1);
    check("halt ir_valid", 32'(bus.ir_valid), 32'd0);
    check("halt address", 32'(bus.address), 32'd41);
    for (int i = 0; i < 10; i++) begin
      bus.branch_abs = 1; bus.branch_rel = i[0]; bus.stall = i[1];
      tick();
      check("halted address", 32'(bus.address), 32'd41);
    end
    check("halted count", 32'(bus.fetch_count), 32'd87);
    check("halted ir_pc", 32'(bus.ir_pc), 32'd40);
    check("halted still", 32'(bus.halted), 32'd1);
    bus.branch_abs = 0; bus.branch_rel = 0; bus.stall = 0; bus.halt = 0;

    // Reset out of HALTED
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_zero("reset halted");
    for (int k = 0; k < 3; k++) tick();
    check("rerun address", 32'(bus.address), 32'd3);
    check("rerun count", 32'(bus.fetch_count), 32'd3);

    // Reset in the middle of a stall
    bus.stall = 1;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bus.stall = 0;
    check_zero("reset stall");

    // Csize=3 counter saturates at 7
    for (int k = 0; k < 6; k++) tick();
    check("sat 6", 32'(bus3.fetch_count), 32'd6);
    tick();
    check("sat 7", 32'(bus3.fetch_count), 32'd7);
    for (int k = 0; k < 3; k++) tick();
    check("sat hold", 32'(bus3.fetch_count), 32'd7);
    check("sat pc moves", 32'(bus3.address), 32'd10);
    check("wide count", 32'(bus.fetch_count), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
